// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory request/response and decode hand-off signals
// for the fetch unit; master is the fetch unit's own view.
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
);
   logic               ImemReqValid;
   logic               ImemReqReady;
   logic [ADDR_W-1:0]  ImemReqAddr;
   logic               ImemRspValid;
   logic [INSTR_W-1:0] ImemRspData;
   logic               RedirectValid;
   logic [ADDR_W-1:0]  RedirectPC;
   logic               FetchValid;
   logic               FetchReady;
   logic [INSTR_W-1:0] FetchInstr;
   logic [ADDR_W-1:0]  FetchPC;

   modport master (
      output ImemReqValid, ImemReqAddr, FetchValid, FetchInstr, FetchPC,
      input  ImemReqReady, ImemRspValid, ImemRspData, RedirectValid, RedirectPC, FetchReady
   );

   modport slave (
      input  ImemReqValid, ImemReqAddr, FetchValid, FetchInstr, FetchPC,
      output ImemReqReady, ImemRspValid, ImemRspData, RedirectValid, RedirectPC, FetchReady
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues in-order word fetches at the fetch PC, buffers returned
// instructions with their PCs, and drops stale responses after a branch redirect.
module instr_fetch_unit #(
   parameter int                ADDR_W     = 64,
   parameter int                INSTR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic CLK,
   input  logic Reset_n,
   instr_fetch_unit_if.master bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [ADDR_W-1:0]  fpc_q, fpc_d, rpc_q, rpc_d;
   logic [CW-1:0]      out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
   logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
   logic [ADDR_W-1:0]  pc_mem_q  [FIFO_DEPTH];
   logic [INSTR_W-1:0] ins_mem_q [FIFO_DEPTH];

   logic credit_ok, req_valid, req_fire, rsp_ok, fetch_valid, push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Credit counts only registered occupancy, so a same-cycle pop frees nothing.
   assign credit_ok   = ({1'b0, out_q} + {1'b0, cnt_q}) < (CW + 1)'(FIFO_DEPTH);
   assign req_valid   = Reset_n && !bus.RedirectValid && credit_ok;
   assign req_fire    = req_valid && bus.ImemReqReady;
   assign rsp_ok      = bus.ImemRspValid && (out_q != '0);
   assign fetch_valid = (cnt_q != '0) && !bus.RedirectValid;

   always_comb begin
      fpc_d  = fpc_q;
      rpc_d  = rpc_q;
      out_d  = out_q;
      drop_d = drop_q;
      cnt_d  = cnt_q;
      rd_d   = rd_q;
      wr_d   = wr_q;
      push   = 1'b0;
      pop    = 1'b0;
      if (bus.RedirectValid) begin
         // Every request still in flight belongs to the old path.
         fpc_d  = bus.RedirectPC;
         rpc_d  = bus.RedirectPC;
         out_d  = out_q - CW'(rsp_ok);
         drop_d = out_q - CW'(rsp_ok);
         cnt_d  = '0;
         rd_d   = '0;
         wr_d   = '0;
      end else begin
         if (req_fire) fpc_d = fpc_q + ADDR_W'(1);
         out_d = out_q + CW'(req_fire) - CW'(rsp_ok);
         if (rsp_ok) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CW'(1);
            end else begin
               push  = 1'b1;
               rpc_d = rpc_q + ADDR_W'(1);
            end
         end
         pop = fetch_valid && bus.FetchReady;
         if (push) wr_d = ptr_inc(wr_q);
         if (pop)  rd_d = ptr_inc(rd_q);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         fpc_q  <= RESET_PC;
         rpc_q  <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
         cnt_q  <= '0;
         rd_q   <= '0;
         wr_q   <= '0;
      end else begin
         fpc_q  <= fpc_d;
         rpc_q  <= rpc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
         cnt_q  <= cnt_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         pc_mem_q[wr_q]  <= rpc_q;
         ins_mem_q[wr_q] <= bus.ImemRspData;
      end
   end

   assign bus.ImemReqValid = req_valid;
   assign bus.ImemReqAddr  = fpc_q;
   assign bus.FetchValid   = fetch_valid;
   assign bus.FetchInstr   = (cnt_q != '0) ? ins_mem_q[rd_q] : '0;
   assign bus.FetchPC      = (cnt_q != '0) ? pc_mem_q[rd_q]  : '0;

`ifndef SYNTHESIS
   a_rsp_has_request: assert property (@(posedge CLK) disable iff (!Reset_n)
      bus.ImemRspValid |-> (out_q != '0))
      else $error("instruction response with no outstanding request");
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench: accepted fetches since the last redirect/reset must be
// delivered in order with PC = fetch address and instruction = memory word at it.
module tb_instr_fetch_unit;
   localparam int          DEPTH    = 2;
   localparam logic [63:0] RESET_PC = 64'h0;

   typedef struct {logic [63:0] addr; bit stale;} pend_t;
   typedef struct {logic [63:0] pc; logic [31:0] instr;} exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

   instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .CLK     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   pend_t       pending[$];
   exp_t        exp_q[$];
   int          buffered = 0;
   logic [63:0] model_fpc = RESET_PC;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return 32'hD000_0000 ^ a[31:0] ^ a[63:32];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
      end
   endtask

   // Scoreboard monitor: every instruction handed to decode must match the queue head.
   always @(negedge clk) begin
      if (rst_n && bus.FetchValid && bus.FetchReady) begin
         if (exp_q.size() == 0) begin
            chk("fetch_unexpected", bus.FetchPC, 64'hXXXX_XXXX_XXXX_XXXX);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("fetch_pc", bus.FetchPC, e.pc);
            chk("fetch_instr", {32'h0, bus.FetchInstr}, {32'h0, e.instr});
         end
      end
   end

   // One clock cycle: drive inputs (called at posedge+1), check and update at negedge.
   task automatic step(input bit rdy, input bit fr, input bit redir,
                       input logic [63:0] tgt, input int rsp_pct);
      pend_t p;
      bit    rsp, reqf, ff;
      bus.ImemReqReady  = rdy;
      bus.FetchReady    = fr;
      bus.RedirectValid = redir;
      bus.RedirectPC    = tgt;
      if (pending.size() != 0 && int'($urandom_range(99)) < rsp_pct) begin
         bus.ImemRspValid = 1'b1;
         bus.ImemRspData  = mem_word(pending[0].addr);
      end else begin
         bus.ImemRspValid = 1'b0;
         bus.ImemRspData  = $urandom;
      end
      @(negedge clk);
      rsp  = bus.ImemRspValid;
      reqf = bus.ImemReqValid && bus.ImemReqReady;
      ff   = bus.FetchValid && bus.FetchReady;
      chk("req_valid", {63'h0, bus.ImemReqValid},
          {63'h0, (!redir && (pending.size() + buffered < DEPTH))});
      chk("fetch_valid", {63'h0, bus.FetchValid}, {63'h0, (buffered > 0 && !redir)});
      if (bus.ImemReqValid) chk("req_addr", bus.ImemReqAddr, model_fpc);
      if (redir) begin
         if (rsp) void'(pending.pop_front());
         foreach (pending[i]) pending[i].stale = 1'b1;
         buffered  = 0;
         exp_q.delete();
         model_fpc = tgt;
      end else begin
         if (rsp) begin
            p = pending.pop_front();
            if (!p.stale) buffered++;
         end
         if (reqf) begin
            pending.push_back('{addr: model_fpc, stale: 1'b0});
            exp_q.push_back('{pc: model_fpc, instr: mem_word(model_fpc)});
            model_fpc = model_fpc + 64'd1;
         end
         if (ff) buffered--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.ImemReqReady = 1'b0; bus.FetchReady = 1'b0; bus.RedirectValid = 1'b0;
      bus.RedirectPC = '0; bus.ImemRspValid = 1'b0; bus.ImemRspData = '0;
      #1;
      chk("rst_req_valid", {63'h0, bus.ImemReqValid}, 64'h0);
      chk("rst_fetch_valid", {63'h0, bus.FetchValid}, 64'h0);
      chk("rst_req_addr", bus.ImemReqAddr, RESET_PC);
      chk("rst_fetch_pc", bus.FetchPC, 64'h0);
      chk("rst_fetch_instr", {32'h0, bus.FetchInstr}, 64'h0);
      pending.delete();
      exp_q.delete();
      buffered  = 0;
      model_fpc = RESET_PC;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [63:0] rand_target();
      case ($urandom_range(3))
         0:       return 64'hFFFF_FFFF_FFFF_FFFE;
         1:       return {56'h0, 8'($urandom)};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      bit done;
      do_reset();
      // streaming with a 1-cycle memory and an always-ready decoder
      repeat (20) step(1, 1, 0, '0, 100);
      // decoder stalls until the buffer fills, then drains
      repeat (8)  step(1, 0, 0, '0, 100);
      repeat (8)  step(1, 1, 0, '0, 100);
      // memory not ready: address must hold
      repeat (5)  step(0, 1, 0, '0, 100);
      repeat (5)  step(1, 1, 0, '0, 100);
      // redirect with requests in flight and buffered instructions
      step(1, 0, 0, '0, 0);
      step(1, 0, 1, 64'h40, 100);
      repeat (10) step(1, 1, 0, '0, 100);
      // redirect colliding with a response and a decode hand-off
      step(1, 1, 1, 64'h80, 100);
      repeat (6)  step(1, 1, 0, '0, 100);
      // randomized traffic
      repeat (3000) begin
         step($urandom_range(99) < 75, $urandom_range(99) < 70,
              $urandom_range(99) < 5, rand_target(), 60);
      end
      // asynchronous reset with a full buffer and requests outstanding
      repeat (4) step(1, 0, 0, '0, 50);
      do_reset();
      repeat (1500) begin
         step($urandom_range(99) < 80, $urandom_range(99) < 60,
              $urandom_range(99) < 4, rand_target(), 70);
      end
      // drain: everything accepted must come out within a bounded time
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         step(0, 1, 0, '0, 100);
         done = (pending.size() == 0) && (buffered == 0) && (exp_q.size() == 0);
      end
      chk("drain_complete", {63'h0, done}, 64'h1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
